// File: rtl/imem_sync.sv
// Loadable synchronous instruction memory with a fetch handshake.
// Fetches take WAIT_STATES extra cycles; out-of-range PCs return NOOP and set fault.
module imem_sync #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              fetch_req,
  input  logic [31:0]       PC,
  output logic [DATA_W-1:0] Instruction,
  output logic              fetch_valid,
  output logic              busy,
  output logic              fault
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [31:0]       pc_q, pc_use;
  logic              accept, complete, in_range;
  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    complete = 1'b0;
    pc_use   = pc_q;
    accept   = fetch_req && (state != WAIT);
    unique case (state)
      WAIT: begin
        if (cnt == '0) begin
          complete = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: begin
        if (accept) begin
          // zero-wait fetches complete on the accepting edge, so PC bypasses pc_q
          if (WAIT_STATES == 0) begin
            complete = 1'b1;
            pc_use   = PC;
            state_d  = DONE;
          end else begin
            cnt_d   = CW'(WAIT_STATES - 1);
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign in_range = (pc_use >> ADDR_W) == '0;
  assign busy     = (state == WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pc_q        <= '0;
      Instruction <= '0;
      fetch_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      fetch_valid <= complete;
      if (accept) pc_q <= PC;
      if (complete) begin
        fault       <= !in_range;
        Instruction <= in_range ? mem[pc_use[ADDR_W-1:0]] : '0;
      end
    end
  end

  // reads above see the pre-write contents on a same-edge collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_imem_sync.sv
// Bench for imem_sync: three instances (0, 3, 4 wait states) on shared stimulus,
// checked against a timestamp-based reference model.
module tb_imem_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_en = 1'b0;
  logic [4:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        fetch_req = 1'b0;
  logic [31:0] PC = '0;

  logic [31:0] ins [3];
  logic        vld [3];
  logic        bsy [3];
  logic        flt [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic int ws(input int i);
    return (i == 0) ? 0 : i + 2;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    imem_sync #(
      .DATA_W(32),
      .ADDR_W(5),
      .WAIT_STATES((g == 0) ? 0 : g + 2)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .load_en(load_en),
      .load_addr(load_addr),
      .load_data(load_data),
      .fetch_req(fetch_req),
      .PC(PC),
      .Instruction(ins[g]),
      .fetch_valid(vld[g]),
      .busy(bsy[g]),
      .fault(flt[g])
    );
  end

  // reference model: a pending fetch is a (pc, due edge) pair
  logic [31:0] mm [32];
  bit          pend [3];
  int          due [3];
  logic [31:0] pcq [3];
  logic [31:0] e_ins [3];
  bit          e_vld [3];
  bit          e_flt [3];
  int          edge_no = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 32; a++) mm[a] = '0;
    for (int i = 0; i < 3; i++) begin
      pend[i]  = 0;
      e_ins[i] = '0;
      e_vld[i] = 0;
      e_flt[i] = 0;
    end
  endtask

  task automatic finish_fetch(input int i, input logic [31:0] p);
    e_vld[i] = 1;
    if (p < 32) begin
      e_ins[i] = mm[p[4:0]];
      e_flt[i] = 0;
    end else begin
      e_ins[i] = '0;
      e_flt[i] = 1;
    end
  endtask

  task automatic model_edge();
    edge_no++;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      e_vld[i] = 0;
      if (pend[i]) begin
        if (edge_no == due[i]) begin
          finish_fetch(i, pcq[i]);
          pend[i] = 0;
        end
      end else if (fetch_req) begin
        if (ws(i) == 0) begin
          finish_fetch(i, PC);
        end else begin
          pend[i] = 1;
          due[i]  = edge_no + ws(i);
          pcq[i]  = PC;
        end
      end
    end
    if (load_en) mm[load_addr] = load_data;
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ws%0d.valid", ws(i)), 32'(vld[i]), 32'(e_vld[i]));
      chk($sformatf("ws%0d.busy", ws(i)), 32'(bsy[i]), 32'(pend[i]));
      chk($sformatf("ws%0d.fault", ws(i)), 32'(flt[i]), 32'(e_flt[i]));
      chk($sformatf("ws%0d.instr", ws(i)), ins[i], e_ins[i]);
    end
  endtask

  // called at a falling edge; applies inputs for the next rising edge
  task automatic cyc(input bit req, input logic [31:0] pc, input bit le,
                     input logic [4:0] la, input logic [31:0] ld);
    fetch_req = req;
    PC        = pc;
    load_en   = le;
    load_addr = la;
    load_data = ld;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  // asynchronous reset asserted between edges, released one cycle later
  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    cyc(1, 32'd3, 0, 5'd0, 32'd0);
    idle(5);

    cyc(0, 32'd0, 1, 5'd1, 32'hC821_0005);
    cyc(0, 32'd0, 1, 5'd2, 32'h1111_2222);
    cyc(0, 32'd0, 1, 5'd3, 32'h3333_4444);
    cyc(0, 32'd0, 1, 5'd7, 32'h7777_0007);
    cyc(0, 32'd0, 1, 5'd9, 32'h9999_0009);
    cyc(0, 32'd0, 1, 5'd4, 32'h4444_0004);
    cyc(1, 32'd1, 0, 5'd0, 32'd0);
    cyc(1, 32'd2, 0, 5'd0, 32'd0);
    cyc(1, 32'd3, 0, 5'd0, 32'd0);
    idle(5);

    cyc(1, 32'd7, 0, 5'd0, 32'd0);
    for (int k = 0; k < 5; k++) cyc(1, 32'd9, 0, 5'd0, 32'd0);
    idle(5);

    cyc(1, 32'd32, 0, 5'd0, 32'd0);
    idle(5);
    cyc(1, 32'd4, 0, 5'd0, 32'd0);
    idle(5);

    // collision aimed at each instance's completion edge in turn
    for (int i = 0; i < 3; i++) begin
      cyc(0, 32'd0, 1, 5'd5, 32'h0000_AAAA);
      if (ws(i) == 0) begin
        cyc(1, 32'd5, 1, 5'd5, 32'h0000_BBBB);
      end else begin
        cyc(1, 32'd5, 0, 5'd0, 32'd0);
        idle(ws(i) - 1);
        cyc(0, 32'd0, 1, 5'd5, 32'h0000_BBBB);
      end
      idle(5);
      cyc(1, 32'd5, 0, 5'd0, 32'd0);
      idle(5);
    end

    cyc(1, 32'd9, 0, 5'd0, 32'd0);
    idle(1);
    do_reset();
    idle(3);
    cyc(0, 32'd0, 1, 5'd6, 32'h6666_0006);
    cyc(1, 32'd6, 0, 5'd0, 32'd0);
    idle(5);

    for (int k = 0; k < 500; k++) begin
      logic [31:0] pc;
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 9) == 0) pc = 32'hFFFF_FF00 | $urandom_range(0, 255);
        else pc = $urandom_range(0, 40);
        cyc(($urandom_range(0, 9) < 7), pc, ($urandom_range(0, 9) < 3),
            5'($urandom_range(0, 31)), $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
